// File: rtl/cla_pkg.sv
// Shared widths for the two-level carry-lookahead adder.
// Group size drives the slice width and the second-level fan-in.
package cla_pkg;
  localparam int ADD_W   = 16;
  localparam int GRP_W   = 4;
  localparam int NUM_GRP = ADD_W / GRP_W;
endpackage

// File: rtl/cla_adder_16bit_if.sv
// Operand/result bundle for the 16-bit lookahead adder.
// The master drives operands; the slave returns the registered sum.
interface cla_adder_16bit_if;
  import cla_pkg::*;
  logic [ADD_W-1:0] A;
  logic [ADD_W-1:0] B;
  logic             Cin;
  logic [ADD_W-1:0] S;
  logic             Cout;
  modport master (
    output A, B, Cin,
    input  S, Cout
  );
  modport slave (
    input  A, B, Cin,
    output S, Cout
  );
endinterface

// File: rtl/cla_slice_4bit.sv
// 4-bit lookahead slice in add mode, 74181 style.
// Exports group generate/propagate for the second-level generator.
module cla_slice_4bit
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             grp_g,
  output logic             grp_p
);
  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] p;
  logic [GRP_W-1:0] c;

  assign g = a & b;
  assign p = a | b;

  // Every internal carry is flattened to sum-of-products, no ripple.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign s = a ^ b ^ c;

  assign grp_g = g[3] | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;
endmodule

// File: rtl/cla_adder_16bit.sv
// 16-bit two-level carry-lookahead adder with registered sum/carry.
// Four slices plus a 74182-style carry generator feeding one flop stage.
module cla_adder_16bit
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADD_W-1:0] A,
  input  logic [ADD_W-1:0] B,
  input  logic             Cin,
  output logic [ADD_W-1:0] S,
  output logic             Cout
);
  logic [NUM_GRP-1:0] gg;
  logic [NUM_GRP-1:0] gp;
  logic [NUM_GRP-1:0] gc;
  logic [ADD_W-1:0]   s_d;
  logic               cout_d;

  for (genvar k = 0; k < NUM_GRP; k++) begin : g_slice
    cla_slice_4bit u_slice (
      .a     (A[k*GRP_W +: GRP_W]),
      .b     (B[k*GRP_W +: GRP_W]),
      .cin   (gc[k]),
      .s     (s_d[k*GRP_W +: GRP_W]),
      .grp_g (gg[k]),
      .grp_p (gp[k])
    );
  end

  assign gc[0] = Cin;
  assign gc[1] = gg[0] | (gp[0] & Cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0])
               | (gp[1] & gp[0] & Cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1])
               | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & Cin);
  assign cout_d = gg[3] | (gp[3] & gg[2])
                | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= s_d;
      Cout <= cout_d;
    end
  end
endmodule

// File: tb/tb_cla_adder_16bit.sv
// Self-checking bench for cla_adder_16bit.
// Results are compared with a plain 17-bit arithmetic reference.
module tb_cla_adder_16bit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cla_adder_16bit_if bus ();

  cla_adder_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (bus.A),
    .B     (bus.B),
    .Cin   (bus.Cin),
    .S     (bus.S),
    .Cout  (bus.Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ref_add(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        c
  );
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    @(negedge clk);
    bus.A   = a;
    bus.B   = b;
    bus.Cin = c;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    bus.A   = 16'hFFFF;
    bus.B   = 16'h0001;
    bus.Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.Cout, bus.S} !== 17'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h/%b want 0000/0", bus.S, bus.Cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.Cout, bus.S} !== 17'h10000) begin
      errors++;
      $display("FAIL reset_release: got %h/%b want 0000/1", bus.S, bus.Cout);
    end
  endtask

  task automatic test_vectors(input string name,
                              input logic [15:0] av[],
                              input logic [15:0] bv[],
                              input logic        cv[]);
    logic [16:0] exp;
    for (int i = 0; i < av.size(); i++) begin
      drive(av[i], bv[i], cv[i]);
      exp = ref_add(av[i], bv[i], cv[i]);
      @(posedge clk);
      #1;
      checks++;
      if ({bus.Cout, bus.S} !== exp) begin
        errors++;
        $display("FAIL %s[%0d]: %h+%h+%b got %h/%b want %h/%b", name, i,
                 av[i], bv[i], cv[i], bus.S, bus.Cout, exp[15:0], exp[16]);
      end
    end
  endtask

  task automatic test_basic;
    logic [15:0] av[] = new[7];
    logic [15:0] bv[] = new[7];
    logic        cv[] = new[7];
    for (int i = 0; i < 7; i++) begin
      av[i] = 16'(2 * i + 1);
      bv[i] = 16'(2 * i + 2);
      cv[i] = 1'b0;
    end
    test_vectors("basic", av, bv, cv);
  endtask

  task automatic test_group_carry;
    logic [15:0] av[] = '{16'h000F, 16'h00FF, 16'h0FFF};
    logic [15:0] bv[] = '{16'h0001, 16'h0001, 16'h0000};
    logic        cv[] = '{1'b0, 1'b0, 1'b1};
    test_vectors("group_carry", av, bv, cv);
  endtask

  task automatic test_overflow;
    logic [15:0] av[] = '{16'hFFFF, 16'h8000, 16'hFFFF};
    logic [15:0] bv[] = '{16'hFFFF, 16'h8000, 16'h0000};
    logic        cv[] = '{1'b1, 1'b0, 1'b1};
    test_vectors("overflow", av, bv, cv);
  endtask

  task automatic test_back_to_back;
    logic [15:0] av[] = '{16'd1, 16'd13, 16'h000F, 16'h00FF,
                          16'h0FFF, 16'hFFFF, 16'h8000, 16'hFFFF};
    logic [15:0] bv[] = '{16'd2, 16'd14, 16'h0001, 16'h0001,
                          16'h0000, 16'hFFFF, 16'h8000, 16'h0000};
    logic        cv[] = '{1'b0, 1'b0, 1'b0, 1'b0,
                          1'b1, 1'b1, 1'b0, 1'b1};
    logic [16:0] exp;
    for (int i = 0; i <= av.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = ref_add(av[i-1], bv[i-1], cv[i-1]);
        checks++;
        if ({bus.Cout, bus.S} !== exp) begin
          errors++;
          $display("FAIL b2b[%0d]: got %h/%b want %h/%b", i - 1,
                   bus.S, bus.Cout, exp[15:0], exp[16]);
        end
      end
      if (i < av.size()) begin
        bus.A   = av[i];
        bus.B   = bv[i];
        bus.Cin = cv[i];
      end
    end
  endtask

  task automatic test_mid_reset;
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.Cout, bus.S} !== 17'h0) begin
      errors++;
      $display("FAIL mid_reset: got %h/%b want 0000/0", bus.S, bus.Cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [16:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom());
      b = 16'($urandom());
      c = 1'($urandom());
      drive(a, b, c);
      exp = ref_add(a, b, c);
      @(posedge clk);
      #1;
      checks++;
      if ({bus.Cout, bus.S} !== exp) begin
        errors++;
        $display("FAIL random[%0d]: %h+%h+%b got %h/%b want %h/%b", i,
                 a, b, c, bus.S, bus.Cout, exp[15:0], exp[16]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_group_carry();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
